shot_judge: RTL and testbench

Resolves player shots on an 8x8 Battleship grid and produces the single-cycle `HIT`/`FAIL` strobes consumed by the seven-segment message display. Sits between the debounced fire-button/coordinate-switch logic and the display. Holds a fixed ship map and a per-cell shot-history bitmap, rejects repeat shots, keeps hit and shot counts, and declares game over when every ship cell has been hit.

---
 rtl/shot_judge.sv | 185 ++++++++++++++++++
 tb/tb_shot_judge.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_judge.sv
// shot_judge: resolves Battleship shots on an 8x8 grid against a fixed ship map.
// Turns a debounced fire button into one-cycle HIT / FAIL / REPEAT strobes.
// Tracks which cells have already been shot, counts hits and valid shots, and
// enters OVER once every ship cell has been hit. new_game restarts from IDLE
// with a clean history.
module shot_judge #(
    parameter logic [63:0] SHIP_MAP   = 64'h000E_8080_8C80_001F,
    parameter int unsigned SHIP_CELLS = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fire,
    input  logic [2:0] x,
    input  logic [2:0] y,
    input  logic       new_game,
    output logic       HIT,
    output logic       FAIL,
    output logic       REPEAT,
    output logic       busy,
    output logic [6:0] hit_count,
    output logic [6:0] shot_count,
    output logic       game_over
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_RESULT = 2'd2;
    localparam logic [1:0] ST_OVER   = 2'd3;

    localparam logic [6:0] SHIP_CELLS_C = 7'(SHIP_CELLS);

    // Reads one cell of a 64-cell grid bitmap (index = y*8 + x).
    function automatic logic cell_bit(input logic [63:0] map, input logic [5:0] idx);
        return map[idx];
    endfunction

    // Returns the grid bitmap with one extra cell marked.
    function automatic logic [63:0] mark_cell(input logic [63:0] map, input logic [5:0] idx);
        return map | (64'd1 << idx);
    endfunction

    // Registered state
    logic [1:0]  state_r;
    logic        fire_q_r;
    logic [5:0]  idx_r;
    logic        ship_bit_r;
    logic        shot_bit_r;
    logic [63:0] history_r;
    logic [6:0]  hit_count_r;
    logic [6:0]  shot_count_r;
    logic        hit_r;
    logic        fail_r;
    logic        repeat_r;
    logic        busy_r;
    logic        game_over_r;

    // Next-state values
    logic [1:0]  state_nxt_s;
    logic [5:0]  idx_nxt_s;
    logic        ship_bit_nxt_s;
    logic        shot_bit_nxt_s;
    logic [63:0] history_nxt_s;
    logic [6:0]  hit_count_nxt_s;
    logic [6:0]  shot_count_nxt_s;
    logic        hit_nxt_s;
    logic        fail_nxt_s;
    logic        repeat_nxt_s;
    logic        fire_rise_s;

    // fire_q starts high after reset so a button held through reset is not a shot.
    assign fire_rise_s = fire & ~fire_q_r;

    // Shot-resolution FSM next-state and datapath; new_game overrides everything.
    always_comb begin
        state_nxt_s      = state_r;
        idx_nxt_s        = idx_r;
        ship_bit_nxt_s   = ship_bit_r;
        shot_bit_nxt_s   = shot_bit_r;
        history_nxt_s    = history_r;
        hit_count_nxt_s  = hit_count_r;
        shot_count_nxt_s = shot_count_r;
        hit_nxt_s        = 1'b0;
        fail_nxt_s       = 1'b0;
        repeat_nxt_s     = 1'b0;

        if (new_game) begin
            // Any latched shot and any coincident fire edge are dropped.
            state_nxt_s      = ST_IDLE;
            idx_nxt_s        = 6'd0;
            ship_bit_nxt_s   = 1'b0;
            shot_bit_nxt_s   = 1'b0;
            history_nxt_s    = 64'd0;
            hit_count_nxt_s  = 7'd0;
            shot_count_nxt_s = 7'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fire_rise_s) begin
                        idx_nxt_s   = {y, x};
                        state_nxt_s = ST_LOOKUP;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_LOOKUP: begin
                    // fire edges here are discarded, not queued.
                    ship_bit_nxt_s = cell_bit(SHIP_MAP, idx_r);
                    shot_bit_nxt_s = cell_bit(history_r, idx_r);
                    state_nxt_s    = ST_RESULT;
                end
                ST_RESULT: begin
                    if (shot_bit_r) begin
                        // Repeat shot: strobe only, no state change.
                        repeat_nxt_s = 1'b1;
                        state_nxt_s  = ST_IDLE;
                    end else begin
                        history_nxt_s    = mark_cell(history_r, idx_r);
                        shot_count_nxt_s = shot_count_r + 7'd1;
                        if (ship_bit_r) begin
                            hit_nxt_s       = 1'b1;
                            hit_count_nxt_s = hit_count_r + 7'd1;
                            if (hit_count_nxt_s == SHIP_CELLS_C) begin
                                state_nxt_s = ST_OVER;
                            end else begin
                                state_nxt_s = ST_IDLE;
                            end
                        end else begin
                            fail_nxt_s  = 1'b1;
                            state_nxt_s = ST_IDLE;
                        end
                    end
                end
                ST_OVER: begin
                    // Game finished: fire is ignored until new_game.
                    state_nxt_s = ST_OVER;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, history, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            fire_q_r     <= 1'b1;
            idx_r        <= 6'd0;
            ship_bit_r   <= 1'b0;
            shot_bit_r   <= 1'b0;
            history_r    <= 64'd0;
            hit_count_r  <= 7'd0;
            shot_count_r <= 7'd0;
            hit_r        <= 1'b0;
            fail_r       <= 1'b0;
            repeat_r     <= 1'b0;
            busy_r       <= 1'b0;
            game_over_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            fire_q_r     <= fire;
            idx_r        <= idx_nxt_s;
            ship_bit_r   <= ship_bit_nxt_s;
            shot_bit_r   <= shot_bit_nxt_s;
            history_r    <= history_nxt_s;
            hit_count_r  <= hit_count_nxt_s;
            shot_count_r <= shot_count_nxt_s;
            hit_r        <= hit_nxt_s;
            fail_r       <= fail_nxt_s;
            repeat_r     <= repeat_nxt_s;
            busy_r       <= (state_nxt_s != ST_IDLE);
            game_over_r  <= (state_nxt_s == ST_OVER);
        end
    end

    assign HIT        = hit_r;
    assign FAIL       = fail_r;
    assign REPEAT     = repeat_r;
    assign busy       = busy_r;
    assign hit_count  = hit_count_r;
    assign shot_count = shot_count_r;
    assign game_over  = game_over_r;

endmodule

// File: tb/tb_shot_judge.sv
// Directed self-checking bench for shot_judge.
module tb_shot_judge;

    logic       clk;
    logic       rst_n;
    logic       fire;
    logic [2:0] x;
    logic [2:0] y;
    logic       new_game;
    logic       HIT;
    logic       FAIL;
    logic       REPEAT;
    logic       busy;
    logic [6:0] hit_count;
    logic [6:0] shot_count;
    logic       game_over;

    int checks;
    int failures;

    shot_judge dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fire       (fire),
        .x          (x),
        .y          (y),
        .new_game   (new_game),
        .HIT        (HIT),
        .FAIL       (FAIL),
        .REPEAT     (REPEAT),
        .busy       (busy),
        .hit_count  (hit_count),
        .shot_count (shot_count),
        .game_over  (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fires one shot at idx; returns just after edge N+2, when the strobe is visible.
    task automatic fire_shot(input logic [5:0] idx);
        @(negedge clk);
        x    = idx[2:0];
        y    = idx[5:3];
        fire = 1'b1;
        @(negedge clk);
        fire = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic start_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fire = 1'b0; new_game = 1'b0; x = 3'd0; y = 3'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({HIT, FAIL, REPEAT, busy, game_over} !== 5'b00000 || hit_count !== 7'd0 || shot_count !== 7'd0) begin
            failures++;
            $display("FAIL reset_outputs: got strobes/busy/over=%b hits=%0d shots=%0d want 00000 0 0",
                     {HIT, FAIL, REPEAT, busy, game_over}, hit_count, shot_count);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({HIT, FAIL, REPEAT, busy, game_over} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_idle: got %b want 00000", {HIT, FAIL, REPEAT, busy, game_over});
        end
    endtask

    task automatic test_hit();
        start_new_game();
        fire_shot(6'd2);
        checks++;
        if ({HIT, FAIL, REPEAT} !== 3'b100 || hit_count !== 7'd1 || shot_count !== 7'd1) begin
            failures++;
            $display("FAIL hit: got HFR=%b hits=%0d shots=%0d want 100 1 1", {HIT, FAIL, REPEAT}, hit_count, shot_count);
        end
        @(negedge clk);
        checks++;
        if ({HIT, FAIL, REPEAT} !== 3'b000) begin
            failures++;
            $display("FAIL hit_one_cycle: got HFR=%b want 000", {HIT, FAIL, REPEAT});
        end
    endtask

    task automatic test_miss();
        start_new_game();
        fire_shot(6'd13);
        checks++;
        if ({HIT, FAIL, REPEAT} !== 3'b010 || hit_count !== 7'd0 || shot_count !== 7'd1) begin
            failures++;
            $display("FAIL miss: got HFR=%b hits=%0d shots=%0d want 010 0 1", {HIT, FAIL, REPEAT}, hit_count, shot_count);
        end
        @(negedge clk);
        checks++;
        if (FAIL !== 1'b0) begin
            failures++;
            $display("FAIL miss_one_cycle: got FAIL=%b want 0", FAIL);
        end
    endtask

    task automatic test_repeat();
        start_new_game();
        fire_shot(6'd2);
        checks++;
        if ({HIT, FAIL, REPEAT} !== 3'b100) begin
            failures++;
            $display("FAIL repeat_first: got HFR=%b want 100", {HIT, FAIL, REPEAT});
        end
        fire_shot(6'd2);
        checks++;
        if ({HIT, FAIL, REPEAT} !== 3'b001 || hit_count !== 7'd1 || shot_count !== 7'd1) begin
            failures++;
            $display("FAIL repeat_second: got HFR=%b hits=%0d shots=%0d want 001 1 1", {HIT, FAIL, REPEAT}, hit_count, shot_count);
        end
    endtask

    task automatic test_game_over();
        logic [5:0] seq [17] = '{6'd0, 6'd1, 6'd13, 6'd2, 6'd3, 6'd4, 6'd23, 6'd8, 6'd26,
                                 6'd27, 6'd31, 6'd39, 6'd60, 6'd47, 6'd49, 6'd50, 6'd51};
        logic       ship [17] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                                  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int exp_hits;
        exp_hits = 0;
        start_new_game();
        for (int i = 0; i < 17; i++) begin
            fire_shot(seq[i]);
            if (ship[i]) exp_hits++;
            checks++;
            if ({HIT, FAIL, REPEAT} !== {ship[i], ~ship[i], 1'b0} || hit_count !== 7'(exp_hits) || shot_count !== 7'(i + 1)) begin
                failures++;
                $display("FAIL game_shot_%0d: got HFR=%b hits=%0d shots=%0d want %b%b0 %0d %0d",
                         i, {HIT, FAIL, REPEAT}, hit_count, shot_count, ship[i], ~ship[i], exp_hits, i + 1);
            end
            if (i == 15) begin
                checks++;
                if (game_over !== 1'b0) begin
                    failures++;
                    $display("FAIL game_not_over_yet: got %b want 0", game_over);
                end
            end
        end
        checks++;
        if (game_over !== 1'b1 || hit_count !== 7'd14 || shot_count !== 7'd17) begin
            failures++;
            $display("FAIL game_over: got over=%b hits=%0d shots=%0d want 1 14 17", game_over, hit_count, shot_count);
        end
        fire_shot(6'd54);
        checks++;
        if ({HIT, FAIL, REPEAT} !== 3'b000 || game_over !== 1'b1 || hit_count !== 7'd14 || shot_count !== 7'd17) begin
            failures++;
            $display("FAIL over_ignores_fire: got HFR=%b over=%b hits=%0d shots=%0d want 000 1 14 17",
                     {HIT, FAIL, REPEAT}, game_over, hit_count, shot_count);
        end
        start_new_game();
        checks++;
        if (game_over !== 1'b0 || busy !== 1'b0 || hit_count !== 7'd0 || shot_count !== 7'd0) begin
            failures++;
            $display("FAIL over_new_game: got over=%b busy=%b hits=%0d shots=%0d want 0 0 0 0",
                     game_over, busy, hit_count, shot_count);
        end
    endtask

    task automatic test_hold_fire();
        int n;
        n = 0;
        start_new_game();
        @(negedge clk);
        x = 3'd5; y = 3'd0; fire = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n += int'(HIT) + int'(FAIL) + int'(REPEAT);
        end
        fire = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n += int'(HIT) + int'(FAIL) + int'(REPEAT);
        end
        checks++;
        if (n != 1 || shot_count !== 7'd1) begin
            failures++;
            $display("FAIL hold_fire: got strobes=%0d shots=%0d want 1 1", n, shot_count);
        end
    endtask

    task automatic test_busy_pulse();
        int n;
        n = 0;
        start_new_game();
        @(negedge clk);
        x = 3'd1; y = 3'd0; fire = 1'b1;
        @(negedge clk);
        fire = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_lookup: got %b want 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_result: got %b want 1", busy);
        end
        fire = 1'b1;
        @(negedge clk);
        fire = 1'b0;
        checks++;
        if (HIT !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_first_shot: got HIT=%b busy=%b want 1 0", HIT, busy);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n += int'(HIT) + int'(FAIL) + int'(REPEAT) + int'(busy);
        end
        checks++;
        if (n != 0 || shot_count !== 7'd1) begin
            failures++;
            $display("FAIL busy_pulse_ignored: got activity=%0d shots=%0d want 0 1", n, shot_count);
        end
    endtask

    task automatic test_reset_hold_fire();
        int n;
        n = 0;
        @(negedge clk);
        rst_n = 1'b0; fire = 1'b1; x = 3'd2; y = 3'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n += int'(HIT) + int'(FAIL) + int'(REPEAT) + int'(busy);
        end
        fire = 1'b0;
        checks++;
        if (n != 0 || shot_count !== 7'd0) begin
            failures++;
            $display("FAIL reset_hold_fire: got activity=%0d shots=%0d want 0 0", n, shot_count);
        end
    endtask

    task automatic test_new_game_priority();
        int n;
        n = 0;
        start_new_game();
        @(negedge clk);
        x = 3'd2; y = 3'd0; fire = 1'b1;
        @(negedge clk);
        fire = 1'b0; new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL new_game_in_lookup_busy: got %b want 0", busy);
        end
        // fire edge coinciding with new_game is dropped
        @(negedge clk);
        x = 3'd3; fire = 1'b1; new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n += int'(HIT) + int'(FAIL) + int'(REPEAT) + int'(busy);
        end
        fire = 1'b0;
        checks++;
        if (n != 0 || hit_count !== 7'd0 || shot_count !== 7'd0) begin
            failures++;
            $display("FAIL new_game_priority: got activity=%0d hits=%0d shots=%0d want 0 0 0", n, hit_count, shot_count);
        end
    endtask

    task automatic test_reset_in_result();
        start_new_game();
        fire_shot(6'd3);
        @(negedge clk);
        x = 3'd4; y = 3'd0; fire = 1'b1;
        @(negedge clk);
        fire = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({HIT, FAIL, REPEAT, busy, game_over} !== 5'b00000 || hit_count !== 7'd0 || shot_count !== 7'd0) begin
            failures++;
            $display("FAIL reset_in_result: got %b hits=%0d shots=%0d want 00000 0 0",
                     {HIT, FAIL, REPEAT, busy, game_over}, hit_count, shot_count);
        end
        @(negedge clk);
        checks++;
        if (HIT !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobe_lost: got HIT=%b want 0", HIT);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_hit();
        test_miss();
        test_repeat();
        test_game_over();
        test_hold_fire();
        test_busy_pulse();
        test_reset_hold_fire();
        test_new_game_priority();
        test_reset_in_result();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
